// File: rtl/lap_sequencer.sv
// Race-level lap controller: synchronizes and debounces the finish-line pattern,
// counts qualified laps against the selected circuit's target and gates driver directions.
module lap_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int GAP_CYCLES      = 25000000,
  parameter int CURVE_LAPS      = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] circuit,
  input  logic       senzor_1,
  input  logic       senzor_5,
  input  logic [1:0] dir_req_a,
  input  logic [1:0] dir_req_b,
  output logic [1:0] directie_driverA,
  output logic [1:0] directie_driverB,
  output logic [7:0] count_ture,
  output logic       lap_pulse,
  output logic       running,
  output logic       race_done,
  output logic       stop
);

  // state | meaning
  // IDLE  | race not started, drivers braked, count cleared
  // RUN   | racing, directions pass through, finish pattern being qualified
  // GAP   | lap just counted, crossings ignored until the gap timer expires
  // DONE  | lap target reached, drivers braked, count held
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] DEB_LAST     = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] GAP_LAST     = 26'(GAP_CYCLES - 1);
  localparam logic [7:0]  CURVE_TARGET = 8'(CURVE_LAPS);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  sync_1;
  logic [1:0]  sync_5;
  logic        finish;
  logic        abort;
  logic        arm;
  logic        qualify;
  logic        pass_nx;
  logic [15:0] deb_cnt;
  logic [25:0] gap_cnt;
  logic [7:0]  target;
  logic        has_target;
  logic [7:0]  count_next;

  assign finish     = sync_1[1] & sync_5[1];
  assign abort      = (circuit == 2'b00);
  assign arm        = start && !abort && ((state == IDLE) || (state == DONE));
  assign qualify    = (state == RUN) && finish && (deb_cnt == DEB_LAST);
  assign count_next = (count_ture == 8'hFF) ? 8'hFF : count_ture + 8'd1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (arm) state_nx = RUN;
      RUN: begin
        if (qualify) state_nx = (has_target && (count_next == target)) ? DONE : GAP;
      end
      GAP: if ((gap_cnt >= GAP_LAST) && !finish) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
    // circuit 00 wins over everything, including a lap qualifying this cycle
    if (abort) state_nx = IDLE;
  end

  // gate with the state being entered so the new gating lands with the state update
  assign pass_nx = (state_nx == RUN) || (state_nx == GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      sync_1           <= 2'b00;
      sync_5           <= 2'b00;
      deb_cnt          <= '0;
      gap_cnt          <= '0;
      target           <= '0;
      has_target       <= 1'b0;
      count_ture       <= '0;
      lap_pulse        <= 1'b0;
      directie_driverA <= 2'b00;
      directie_driverB <= 2'b00;
    end else begin
      sync_1    <= {sync_1[0], senzor_1};
      sync_5    <= {sync_5[0], senzor_5};
      state     <= state_nx;
      lap_pulse <= qualify && !abort;

      if (abort || arm) count_ture <= '0;
      else if (qualify) count_ture <= count_next;

      if (arm) begin
        has_target <= (circuit != 2'b11);
        target     <= (circuit == 2'b01) ? 8'd1 : CURVE_TARGET;
      end

      if ((state != RUN) || (state_nx != state) || !finish) deb_cnt <= '0;
      else deb_cnt <= deb_cnt + 16'd1;

      // timer parks at its last value; only the >= compare matters after that
      if ((state != GAP) || (state_nx != state)) gap_cnt <= '0;
      else if (gap_cnt < GAP_LAST) gap_cnt <= gap_cnt + 26'd1;

      directie_driverA <= pass_nx ? dir_req_a : 2'b00;
      directie_driverB <= pass_nx ? dir_req_b : 2'b00;
    end
  end

  assign running   = (state == RUN) || (state == GAP);
  assign race_done = (state == DONE);
  assign stop      = (state == IDLE) || (state == DONE);

endmodule

// File: doc/lap_sequencer.md
# lap_sequencer

Race-level controller between the line-follower direction logic and the motor drivers. Synchronizes and debounces the finish-line pattern (outer sensors both on black) and counts qualified laps. Enforces the lap target of the selected circuit and gates the requested driver directions to brake (2'b00) when the race is idle or finished. Replaces ad-hoc combinational lap counting with a clocked state machine.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive synchronized cycles with both outer sensors high needed to qualify a crossing (range 1..65535).
- GAP_CYCLES, 25000000: minimum cycles after a counted lap before the next crossing can be counted (range 1..2^26-1).
- CURVE_LAPS, 10: lap target for circuit 2'b10 (range 1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  synchronous start request, level; acted on when high in IDLE or DONE.
- circuit  in  2  circuit select: 00 = reset/idle, 01 = straight line (1 lap), 10 = curves (CURVE_LAPS), 11 = endurance (no target).
- senzor_1  in  1  right outer sensor, raw (1 = black).
- senzor_5  in  1  left outer sensor, raw (1 = black).
- dir_req_a  in  2  direction requested for driver A by movement logic.
- dir_req_b  in  2  direction requested for driver B.
- directie_driverA  out  2  gated direction to driver A, registered.
- directie_driverB  out  2  gated direction to driver B, registered.
- count_ture  out  8  qualified laps since last start, saturating at 255.
- lap_pulse  out  1  one-cycle strobe per counted lap.
- running  out  1  high in RUN and GAP.
- race_done  out  1  high in DONE.
- stop  out  1  brake light; high in IDLE and DONE.

## Operation
- Raw senzor_1 and senzor_5 each pass through a 2-flop synchronizer. `finish` = both synchronized bits high.
- 16-bit debounce counter: increments while `finish` is high in RUN. It clears when `finish` is low and on every state change.
- States:
  - IDLE: outputs brake, count cleared. Goes to RUN when start = 1 and circuit != 00. On that transition, target is latched: 01 → 1, 10 → CURVE_LAPS, 11 → none.
  - RUN: directions pass through. When the debounce counter reaches DEBOUNCE_CYCLES-1 with `finish` high, the next edge does the following:
    - count_ture increments (saturating);
    - lap_pulse = 1 for one cycle;
    - state goes to GAP, or to DONE if the new count equals the target.
  - GAP: directions pass through; no counting. A 26-bit gap timer runs from 0. Returns to RUN when timer ≥ GAP_CYCLES-1 and `finish` has been low for at least 1 synchronized cycle. If `finish` stays high, remain in GAP.
  - DONE: directions forced 00, race_done = 1, count held. start = 1 with circuit != 00 clears count, relatches target, and goes to RUN.
- circuit == 00 in any state forces IDLE on the next edge and clears count_ture. This has priority over all other transitions, including a simultaneous lap qualification.
- circuit changes other than to 00 are ignored outside IDLE/DONE; the latched target is used.
- Endurance: count saturates at 255 and never enters DONE. lap_pulse still fires at saturation, but the count does not wrap.

## Timing
- Reset values: state IDLE, directie_driverA = directie_driverB = 2'b00, count_ture = 0, lap_pulse = 0, running = 0, race_done = 0, stop = 1; all counters and synchronizer flops cleared.
- Lap latency: raw sensors both high from the sampling edge of cycle N (in RUN, held) → lap_pulse and the new count_ture visible in cycle N+2+DEBOUNCE_CYCLES.
- A high pulse shorter than DEBOUNCE_CYCLES synchronized cycles is never counted; any low sample restarts qualification.
- Direction outputs are registered:
  - dir_req changes appear one cycle later;
  - on a state change, the gating of the new state applies in the same cycle the state register updates.
- running, race_done and stop are decoded from the state register (no extra latency).
- Asynchronous reset mid-race returns to the reset values immediately; no lap is counted by the reset edge.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, GAP_CYCLES=8, CURVE_LAPS=3.
- Reset: rst_n low mid-RUN with count 2 → outputs 00/00, count 0, stop 1 asynchronously; after release, IDLE holds until start.
- Straight race: circuit=01, start, dir_req 10/10 → outputs 10/10 one cycle later. Sensors both high 10 cycles → lap_pulse at cycle N+6, count 1, DONE, outputs 00/00, race_done 1.
- Debounce: circuit=10, run, sensors high 3 cycles, low 1, high 3 → no lap_pulse, count 0. Then high 4 → count 1, state GAP.
- Gap rule: after a lap, sensors held high 20 cycles → only one lap counted. Drop low, raise again for 4 cycles after the gap → count 2. Third lap → DONE at count 3.
- Endurance saturation: circuit=11, preload via 255 laps → count stays 255 on lap 256, lap_pulse still fires, never DONE.
- Abort priority: circuit forced 00 in the same cycle a lap qualifies → IDLE, count 0, no lap_pulse. Restart from DONE with start clears count and resumes RUN.
